posit_batch_sequencer: RTL

Sequences batches of posit operations through the posit arithmetic datapath without HPS intervention per operation. On a start edge from the HPS control PIO it fetches operand pairs from the on-chip memory second port, issues each pair to the datapath with a valid/ready handshake, and writes each 32-bit result back to the same memory. It then raises `completed` toward the HPS completion PIO. It sits in the FPGA fabric between the Qsys system's onchip_memory2_0 s2 port, its start/completed PIOs, and the posit unit.

---
 rtl/posit_batch_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/posit_batch_sequencer.sv
// posit_batch_sequencer: fetches operand pairs from memory, runs them through the posit datapath and writes results back
// Ports: clock/reset (sync, active-high); start level plus cfg_count/cfg_src/cfg_dst captured on its accepted rising edge;
// completed/busy/ops_done/timeout_flag status; mem_* drive a byte-wide memory port with 1-cycle read latency;
// op_valid/op_ready/op_a/op_b issue operand pairs; res_valid/res_data return the 32-bit result.
// Optional feature: define POSIT_SEQ_TIMEOUT_EN to force NaR after TIMEOUT result-less WAIT cycles.
module posit_batch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  output logic              completed,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done,
  output logic              timeout_flag,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [7:0]        mem_writedata,
  input  logic [7:0]        mem_readdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  input  logic              res_valid,
  input  logic [31:0]       res_data
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic start_q, go, fetch_rd, expire;
  logic [3:0] sub;
  logic [CNT_W-1:0] count, idx;
  logic [ADDR_W-1:0] src, dst;
  logic [55:0] bytes;
  logic [31:0] result;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be positive");
  end
  assign go = start && !start_q && (state == IDLE || state == DONE);
  assign fetch_rd = state == FETCH && sub != 4'd8;
  assign completed = state == DONE;
  assign busy = state != IDLE && state != DONE;
  assign op_valid = state == ISSUE;
  assign mem_write = state == WRITE;
  assign mem_chipselect = fetch_rd || mem_write;
  assign mem_clken = mem_chipselect;
  assign mem_writedata = mem_write ? result[{sub[1:0], 3'b000} +: 8] : '0;
  assign mem_address = fetch_rd ? src + ADDR_W'({idx, 3'b000}) + ADDR_W'(sub)
                     : mem_write ? dst + ADDR_W'({idx, 2'b00}) + ADDR_W'(sub) : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = go ? (cfg_count == '0 ? DONE : FETCH) : state;
      FETCH: state_nx = sub == 4'd8 ? ISSUE : FETCH;
      ISSUE: state_nx = op_ready ? WAIT : ISSUE;
      WAIT: state_nx = res_valid || expire ? WRITE : WAIT;
      WRITE: state_nx = sub != 4'd3 ? WRITE : (idx + CNT_W'(1) == count ? DONE : FETCH);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      start_q <= 1'b0;
      sub <= '0;
      count <= '0;
      idx <= '0;
      src <= '0;
      dst <= '0;
      bytes <= '0;
      result <= '0;
      op_a <= '0;
      op_b <= '0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      start_q <= start;
      // sub is the per-state byte counter (j in FETCH, k in WRITE); restarts on every state change
      sub <= state_nx != state ? '0 : sub + 4'd1;
      if (go) begin
        count <= cfg_count;
        src <= cfg_src;
        dst <= cfg_dst;
        idx <= '0;
        ops_done <= '0;
      end
      // read data lags the address by one cycle, so bytes 0..6 shift in at j=1..7 and byte 7 arrives at j=8
      if (state == FETCH && sub != 4'd0 && sub != 4'd8)
        bytes <= {mem_readdata, bytes[55:8]};
      // operands update only once the whole pair is in, so they stay stable through ISSUE and beyond
      if (state == FETCH && sub == 4'd8) begin
        op_a <= bytes[31:0];
        op_b <= {mem_readdata, bytes[55:32]};
      end
      if (state == WAIT && (res_valid || expire))
        result <= expire ? 32'h8000_0000 : res_data;
      if (state == WRITE && sub == 4'd3) begin
        ops_done <= ops_done + CNT_W'(1);
        idx <= idx + CNT_W'(1);
      end
    end
  end
`ifdef POSIT_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt;
  assign expire = state == WAIT && !res_valid && wait_cnt == TO_W'(TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wait_cnt <= state == WAIT ? wait_cnt + TO_W'(1) : '0;
      timeout_flag <= go ? 1'b0 : timeout_flag || expire;
    end
  end
`else
  assign expire = 1'b0;
  assign timeout_flag = 1'b0;
`endif
endmodule
